// File: rtl/bus_cycle_ctl.sv
// Data-bus cycle sequencer: qualifies microcode memory/IO requests, orders the
// bus-enable and read/write strobes, inserts wait states and aborts hung cycles.
module bus_cycle_ctl #(
   parameter int unsigned MEM_WS  = 0,
   parameter int unsigned IO_WS   = 1,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic clk4,
   input  logic nreset,
   input  logic nreq,
   input  logic nmem,
   input  logic nio,
   input  logic nwen,
   input  logic nws,
   output logic nbusen,
   output logic nrd,
   output logic nw,
   output logic wshold,
   output logic ndone,
   output logic nberr,
   output logic busy
);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      STROBE,
      RECOVER,
      ERROR
   } state_t;

   localparam logic [2:0] MEM_WS_C  = 3'(MEM_WS);
   localparam logic [2:0] IO_WS_C   = 3'(IO_WS);
   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   state_t     state_q, state_d;
   logic [2:0] waitCnt_q, waitCnt_d;
   logic [7:0] toCnt_q, toCnt_d;
   logic       write_q, write_d;

   logic nbusen_q, nbusen_d;
   logic nrd_q, nrd_d;
   logic nw_q, nw_d;
   logic wshold_q, wshold_d;
   logic ndone_q, ndone_d;
   logic nberr_q, nberr_d;
   logic busy_q, busy_d;

   always_comb begin
      state_d   = state_q;
      waitCnt_d = waitCnt_q;
      toCnt_d   = toCnt_q;
      write_d   = write_q;
      case (state_q)
         IDLE: begin
            if (!nreq) begin
               if (nmem ^ nio) begin
                  state_d   = ADDR;
                  write_d   = ~nwen;
                  waitCnt_d = !nmem ? MEM_WS_C : IO_WS_C;
                  toCnt_d   = '0;
               end else begin
                  state_d = ERROR;
               end
            end
         end
         ADDR: state_d = STROBE;
         STROBE: begin
            // Programmed wait states take priority; device waits only count after them.
            if (waitCnt_q != 3'd0) begin
               waitCnt_d = waitCnt_q - 3'd1;
            end else if (!nws) begin
               if (toCnt_q == TIMEOUT_C) begin
                  state_d = ERROR;
               end else begin
                  toCnt_d = toCnt_q + 8'd1;
               end
            end else begin
               state_d = RECOVER;
            end
         end
         RECOVER: state_d = IDLE;
         ERROR:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state and registered, so they line up
   // with the state register without any input-to-output combinational path.
   always_comb begin
      nbusen_d = !(state_d == ADDR || state_d == STROBE || state_d == RECOVER);
      nrd_d    = !(state_d == STROBE && !write_d);
      nw_d     = !(state_d == STROBE && write_d);
      wshold_d = (state_d == ADDR || state_d == STROBE);
      ndone_d  = (state_d != RECOVER);
      nberr_d  = (state_d != ERROR);
      busy_d   = (state_d != IDLE);
   end

   always_ff @(posedge clk4) begin
      if (!nreset) begin
         state_q   <= IDLE;
         waitCnt_q <= '0;
         toCnt_q   <= '0;
         write_q   <= 1'b0;
         nbusen_q  <= 1'b1;
         nrd_q     <= 1'b1;
         nw_q      <= 1'b1;
         wshold_q  <= 1'b0;
         ndone_q   <= 1'b1;
         nberr_q   <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         waitCnt_q <= waitCnt_d;
         toCnt_q   <= toCnt_d;
         write_q   <= write_d;
         nbusen_q  <= nbusen_d;
         nrd_q     <= nrd_d;
         nw_q      <= nw_d;
         wshold_q  <= wshold_d;
         ndone_q   <= ndone_d;
         nberr_q   <= nberr_d;
         busy_q    <= busy_d;
      end
   end

   assign nbusen = nbusen_q;
   assign nrd    = nrd_q;
   assign nw     = nw_q;
   assign wshold = wshold_q;
   assign ndone  = ndone_q;
   assign nberr  = nberr_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_bus_cycle_ctl.sv
// Self-checking bench for bus_cycle_ctl with default parameters
// (MEM_WS=0, IO_WS=1, TIMEOUT=15): vector table, scoreboard queue, corner sequences.
module tb_bus_cycle_ctl;

   logic clk4 = 1'b0;
   logic nreset, nreq, nmem, nio, nwen, nws;
   logic nbusen, nrd, nw, wshold, ndone, nberr, busy;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int nmem; int nio; int nwen; int ext;
      int busy; int rd; int w; int done; int err; int busen; int wshold;
   } vec_t;

   typedef struct {
      int busy; int rd; int w; int done; int err; int busen; int wshold; int viol;
   } res_t;

   vec_t vecs[10];
   res_t expQ[$];

   bus_cycle_ctl dut (
      .clk4(clk4), .nreset(nreset), .nreq(nreq), .nmem(nmem), .nio(nio),
      .nwen(nwen), .nws(nws), .nbusen(nbusen), .nrd(nrd), .nw(nw),
      .wshold(wshold), .ndone(ndone), .nberr(nberr), .busy(busy)
   );

   // Clock generation
   always #5 clk4 = ~clk4;

   task automatic checkVal(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drive the request for one vector and push its expected outcome.
   task automatic applyStimulus(input vec_t v);
      res_t e;
      nreq = 1'b0;
      nmem = (v.nmem != 0);
      nio  = (v.nio != 0);
      nwen = (v.nwen != 0);
      nws  = 1'b1;
      e.busy = v.busy; e.rd = v.rd; e.w = v.w; e.done = v.done; e.err = v.err;
      e.busen = v.busen; e.wshold = v.wshold; e.viol = 0;
      expQ.push_back(e);
   endtask

   // Pop the oldest expected record and compare it with what was observed.
   task automatic checkOutput(input string tag, input res_t o);
      res_t e;
      checks++;
      if (expQ.size() == 0) begin
         errors++;
         $display("[TB] FAIL %s scoreboard: got empty queue expected entry", tag);
         return;
      end
      e = expQ.pop_front();
      checkVal({tag, " busy cycles"}, o.busy, e.busy);
      checkVal({tag, " nrd low cycles"}, o.rd, e.rd);
      checkVal({tag, " nw low cycles"}, o.w, e.w);
      checkVal({tag, " ndone pulses"}, o.done, e.done);
      checkVal({tag, " nberr pulses"}, o.err, e.err);
      checkVal({tag, " nbusen low cycles"}, o.busen, e.busen);
      checkVal({tag, " wshold cycles"}, o.wshold, e.wshold);
      checkVal({tag, " strobe protocol violations"}, o.viol, e.viol);
   endtask

   task automatic runVector(input string tag, input vec_t v);
      res_t o;
      int s = 0;
      int ws;
      bit seen = 0;
      bit fin = 0;
      o = '{default: 0};
      ws = (v.nmem == 0) ? 0 : 1;
      applyStimulus(v);
      for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
         @(negedge clk4);
         if (cyc == 0) begin
            nreq = 1'b1;
            nmem = 1'($urandom);
            nio  = 1'($urandom);
            nwen = 1'($urandom);
         end
         if (busy) begin
            seen = 1;
            o.busy++;
         end else if (seen) begin
            fin = 1;
         end
         if (!nrd) o.rd++;
         if (!nw) o.w++;
         if (!ndone) o.done++;
         if (!nberr) o.err++;
         if (!nbusen) o.busen++;
         if (wshold) o.wshold++;
         if (!nrd && !nw) o.viol++;
         if ((!nrd || !nw) && nbusen) o.viol++;
         if (!nrd || !nw) begin
            s++;
            if (s <= ws) nws = 1'($urandom);
            else if (s <= ws + v.ext) nws = 1'b0;
            else nws = 1'b1;
         end else begin
            nws = 1'b1;
         end
      end
      checkVal({tag, " completed within bound"}, int'(fin), 1);
      checkOutput(tag, o);
   endtask

   initial begin
      int addrIdx[$];
      int rdLow;
      int overlap;
      int pulses;
      bit drained;

      // nmem nio nwen ext | busy rd w done err busen wshold
      vecs[0] = '{0, 1, 1, 0,    3,  1,  0, 1, 0,  3,  2};
      vecs[1] = '{0, 1, 0, 0,    3,  0,  1, 1, 0,  3,  2};
      vecs[2] = '{1, 0, 1, 0,    4,  2,  0, 1, 0,  4,  3};
      vecs[3] = '{1, 0, 0, 3,    7,  0,  5, 1, 0,  7,  6};
      vecs[4] = '{0, 1, 1, 2,    5,  3,  0, 1, 0,  5,  4};
      vecs[5] = '{0, 1, 1, 15,  18, 16,  0, 1, 0, 18, 17};
      vecs[6] = '{0, 1, 1, 16,  18, 16,  0, 0, 1, 17, 17};
      vecs[7] = '{1, 0, 0, 255, 19,  0, 17, 0, 1, 18, 18};
      vecs[8] = '{0, 0, 1, 0,    1,  0,  0, 0, 1,  0,  0};
      vecs[9] = '{1, 1, 0, 0,    1,  0,  0, 0, 1,  0,  0};

      nreset = 1'b0; nreq = 1'b1; nmem = 1'b1; nio = 1'b1; nwen = 1'b1; nws = 1'b1;
      repeat (2) @(negedge clk4);
      checkVal("reset nbusen", int'(nbusen), 1);
      checkVal("reset nrd", int'(nrd), 1);
      checkVal("reset nw", int'(nw), 1);
      checkVal("reset wshold", int'(wshold), 0);
      checkVal("reset ndone", int'(ndone), 1);
      checkVal("reset nberr", int'(nberr), 1);
      checkVal("reset busy", int'(busy), 0);
      nreset = 1'b1;
      @(negedge clk4);

      for (int i = 0; i < 10; i++) runVector($sformatf("vec%0d", i), vecs[i]);

      // Reset in the middle of a stretched I/O write strobe
      nreq = 1'b0; nmem = 1'b1; nio = 1'b0; nwen = 1'b0; nws = 1'b0;
      @(negedge clk4);
      nreq = 1'b1;
      repeat (2) @(negedge clk4);
      checkVal("midreset strobe active before reset", int'(nw), 0);
      nreset = 1'b0;
      @(negedge clk4);
      checkVal("midreset nw", int'(nw), 1);
      checkVal("midreset nbusen", int'(nbusen), 1);
      checkVal("midreset busy", int'(busy), 0);
      checkVal("midreset ndone", int'(ndone), 1);
      checkVal("midreset nberr", int'(nberr), 1);
      nreset = 1'b1; nws = 1'b1;
      pulses = 0;
      repeat (3) begin
         @(negedge clk4);
         if (!ndone || !nberr || busy) pulses++;
      end
      checkVal("midreset quiet after release", pulses, 0);
      runVector("postreset", vecs[0]);

      // Back-to-back memory writes with nreq held low
      nreq = 1'b0; nmem = 1'b0; nio = 1'b1; nwen = 1'b0; nws = 1'b1;
      rdLow = 0; overlap = 0;
      for (int c = 0; c < 50 && addrIdx.size() < 2; c++) begin
         @(negedge clk4);
         if (!nrd) rdLow++;
         if (!nrd && !nw) overlap++;
         if (!nbusen && nrd && nw && wshold) addrIdx.push_back(c);
      end
      nreq = 1'b1;
      checkVal("b2b two ADDR cycles seen", addrIdx.size(), 2);
      if (addrIdx.size() == 2)
         checkVal("b2b ADDR spacing", addrIdx[1] - addrIdx[0], 4);
      drained = 0;
      for (int c = 0; c < 50 && !drained; c++) begin
         @(negedge clk4);
         if (!nrd) rdLow++;
         if (!nrd && !nw) overlap++;
         if (!busy) drained = 1;
      end
      checkVal("b2b returned to idle", int'(drained), 1);
      checkVal("b2b nrd low cycles", rdLow, 0);
      checkVal("b2b strobe overlap", overlap, 0);
      checkVal("scoreboard drained", expQ.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
